// File: rtl/two_power_arbiter.sv
// two_power_arbiter
//   Round-robin arbiter sharing one two_power engine (2^power mod modulus)
//   among NUM_REQ requesters. One job in flight at a time.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_valid       per-requester job request
//   req_ready       per-requester accept (one-hot or zero, only in IDLE)
//   req_power       packed power operands, slot i at [i*INT_WIDTH +: INT_WIDTH]
//   req_modulus     packed moduli, slot i at [i*MOD_WIDTH +: MOD_WIDTH]
//   rsp_valid       per-requester result valid (one-hot or zero)
//   rsp_ready       per-requester result accept (only grant_id's bit is used)
//   rsp_data        shared result bus, meaningful where rsp_valid is set
//   tp_i_valid/tp_i_ready/tp_power/tp_modulus   engine request channel
//   tp_o_valid/tp_o_ready/tp_result             engine result channel
//   grant_id        index of the current/last granted requester
//   busy            high in any state other than IDLE
//   job_count       completed jobs, saturating at 0xFFFF
module two_power_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MOD_WIDTH = 256,
    parameter int INT_WIDTH = 256,
    localparam int GW       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INT_WIDTH-1:0]   req_power,
    input  logic [NUM_REQ*MOD_WIDTH-1:0]   req_modulus,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [MOD_WIDTH-1:0]           rsp_data,
    output logic                           tp_i_valid,
    input  logic                           tp_i_ready,
    output logic [INT_WIDTH-1:0]           tp_power,
    output logic [MOD_WIDTH-1:0]           tp_modulus,
    input  logic                           tp_o_valid,
    output logic                           tp_o_ready,
    input  logic [MOD_WIDTH-1:0]           tp_result,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy,
    output logic [15:0]                    job_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           state;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        grant_q;
    logic [INT_WIDTH-1:0] power_q;
    logic [MOD_WIDTH-1:0] modulus_q;
    logic [MOD_WIDTH-1:0] result_q;

    logic                 found;
    logic [GW-1:0]        winner;
    logic [GW-1:0]        cand;
    logic [INT_WIDTH-1:0] sel_power;
    logic [MOD_WIDTH-1:0] sel_modulus;
    logic                 accept;
    logic                 bypass;

    // Rotating priority scan starting just after the last served requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        sel_power   = req_power[winner*INT_WIDTH +: INT_WIDTH];
        sel_modulus = req_modulus[winner*MOD_WIDTH +: MOD_WIDTH];
    end

    assign accept = (state == S_IDLE) && found;
    // Modulus 0 or 1 has a trivial result of 0; skip the engine entirely.
    assign bypass = sel_modulus < MOD_WIDTH'(2);

    // req_ready is combinational from req_valid, so it is also gated by rst
    // to keep every output low while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst && accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    assign rsp_data   = result_q;
    assign tp_i_valid = (state == S_ISSUE);
    assign tp_o_ready = (state == S_WAIT);
    assign tp_power   = power_q;
    assign tp_modulus = modulus_q;
    assign grant_id   = grant_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            power_q    <= '0;
            modulus_q  <= '0;
            result_q   <= '0;
            job_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_q   <= winner;
                        power_q   <= sel_power;
                        modulus_q <= sel_modulus;
                        if (bypass) begin
                            result_q <= '0;
                            state    <= S_RESP;
                        end else begin
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (tp_i_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tp_o_valid) begin
                        result_q <= tp_result;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant_q]) begin
                        last_grant <= grant_q;
                        if (job_count != 16'hFFFF) begin
                            job_count <= job_count + 16'd1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_two_power_arbiter.sv
// Testbench for two_power_arbiter: transaction-level reference model with a
// per-cycle compare process, a small engine responder, and directed scenarios.
module tb_two_power_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_power;
    logic [63:0] req_modulus;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        tp_i_valid;
    logic        tp_i_ready;
    logic [15:0] tp_power;
    logic [15:0] tp_modulus;
    logic        tp_o_valid;
    logic        tp_o_ready;
    logic [15:0] tp_result;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] job_count;

    int checks = 0;
    int errors = 0;
    int grant_log[$];

    two_power_arbiter #(
        .NUM_REQ  (4),
        .MOD_WIDTH(16),
        .INT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_power  (req_power),
        .req_modulus(req_modulus),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .tp_i_valid (tp_i_valid),
        .tp_i_ready (tp_i_ready),
        .tp_power   (tp_power),
        .tp_modulus (tp_modulus),
        .tp_o_valid (tp_o_valid),
        .tp_o_ready (tp_o_ready),
        .tp_result  (tp_result),
        .grant_id   (grant_id),
        .busy       (busy),
        .job_count  (job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= 4; off++) begin
            int j = (last + off) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] pow2mod(input logic [15:0] p, input logic [15:0] m);
        longint r = 1;
        longint b = 2 % longint'(m);
        for (int i = 0; i < 16; i++) begin
            if (p[i]) r = (r * b) % longint'(m);
            b = (b * b) % longint'(m);
        end
        return 16'(r % longint'(m));
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 presenting operands, 2 awaiting engine, 3 responding
    int          m_phase;
    int          m_last;
    int          m_id;
    logic [15:0] m_pow;
    logic [15:0] m_mod;
    logic [15:0] m_res;
    int          m_jobs;
    int          m_win;

    always_comb m_win = pick(req_valid, m_last);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_last  <= 3;
            m_id    <= 0;
            m_pow   <= '0;
            m_mod   <= '0;
            m_res   <= '0;
            m_jobs  <= 0;
        end else begin
            case (m_phase)
                0: if (m_win >= 0) begin
                    m_id  <= m_win;
                    m_pow <= req_power[m_win*16 +: 16];
                    m_mod <= req_modulus[m_win*16 +: 16];
                    if (req_modulus[m_win*16 +: 16] < 16'd2) begin
                        m_res   <= '0;
                        m_phase <= 3;
                    end else begin
                        m_phase <= 1;
                    end
                end
                1: if (tp_i_ready) m_phase <= 2;
                2: if (tp_o_valid) begin
                    m_res   <= tp_result;
                    m_phase <= 3;
                end
                default: if (rsp_ready[m_id]) begin
                    m_last  <= m_id;
                    m_jobs  <= (m_jobs < 65535) ? m_jobs + 1 : m_jobs;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("req_ready", {28'd0, req_ready},
              (rst && m_phase == 0 && m_win >= 0) ? (32'd1 << m_win) : 32'd0);
        check("rsp_valid", {28'd0, rsp_valid}, (m_phase == 3) ? (32'd1 << m_id) : 32'd0);
        check("tp_i_valid", {31'd0, tp_i_valid}, {31'd0, m_phase == 1});
        check("tp_o_ready", {31'd0, tp_o_ready}, {31'd0, m_phase == 2});
        check("busy", {31'd0, busy}, {31'd0, m_phase != 0});
        check("grant_id", {30'd0, grant_id}, m_id);
        check("job_count", {16'd0, job_count}, m_jobs);
        if (m_phase == 3 || !rst) check("rsp_data", {16'd0, rsp_data}, {16'd0, m_res});
        if (m_phase == 1 || !rst) begin
            check("tp_power", {16'd0, tp_power}, {16'd0, m_pow});
            check("tp_modulus", {16'd0, tp_modulus}, {16'd0, m_mod});
        end
    end

    // Grant monitor: records each accepted requester index.
    always @(negedge clk) begin
        if (rst && req_ready != 4'd0) begin
            for (int i = 0; i < 4; i++) if (req_ready[i]) grant_log.push_back(i);
        end
    end

    // ---------------- engine responder (fixed latency) ----------------
    initial begin
        logic        hs_in;
        logic        hs_out;
        logic        rst_s;
        logic [15:0] res;
        int          cnt;
        tp_o_valid = 1'b0;
        tp_result  = '0;
        cnt        = -1;
        res        = '0;
        forever begin
            @(negedge clk);
            hs_in  = tp_i_valid && tp_i_ready;
            hs_out = tp_o_valid && tp_o_ready;
            rst_s  = rst;
            if (hs_in) res = pow2mod(tp_power, tp_modulus);
            @(posedge clk);
            #1;
            if (!rst_s) begin
                tp_o_valid = 1'b0;
                cnt        = -1;
            end else begin
                if (hs_out) tp_o_valid = 1'b0;
                if (hs_in) begin
                    cnt = 2;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        tp_o_valid = 1'b1;
                        tp_result  = res;
                        cnt        = -1;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] p, input logic [15:0] m);
        req_power[i*16 +: 16]   = p;
        req_modulus[i*16 +: 16] = m;
    endtask

    task automatic wait_rsp(input int id);
        int n = 0;
        while (!rsp_valid[id] && n < 50) begin
            tick;
            n++;
        end
        check("rsp_wait", {31'd0, rsp_valid[id]}, 32'd1);
    endtask

    task automatic wait_jobs(input int target);
        int n = 0;
        while (job_count != 16'(target) && n < 200) begin
            tick;
            n++;
        end
        check("jobs_wait", {16'd0, job_count}, target);
    endtask

    task automatic wait_grants(input int target);
        int n = 0;
        while (grant_log.size() < target && n < 200) begin
            tick;
            n++;
        end
        check("grants_wait", grant_log.size(), target);
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
    endtask

    initial begin
        int jc;
        int exp4[4];
        int exp2[2];
        exp4 = '{0, 1, 2, 3};
        exp2 = '{1, 3};
        rst         = 1'b0;
        req_valid   = '0;
        req_power   = '0;
        req_modulus = '0;
        rsp_ready   = '0;
        tp_i_ready  = 1'b1;
        repeat (2) tick;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_job_count", {16'd0, job_count}, 32'd0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        tick;
        rst = 1'b1;
        tick;

        // Single job: 2^3 mod 5 = 3
        set_req(0, 16'd3, 16'd5);
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        check("single_tp_power", {16'd0, tp_power}, 32'd3);
        check("single_tp_modulus", {16'd0, tp_modulus}, 32'd5);
        wait_rsp(0);
        check("single_rsp_data", {16'd0, rsp_data}, 32'd3);
        rsp_ready = 4'b0001;
        tick;
        rsp_ready = '0;
        check("single_job_count", {16'd0, job_count}, 32'd1);

        // Round robin from reset: 0,1,2,3 then {1,3} -> 1,3
        apply_reset;
        for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 16'd11);
        rsp_ready = 4'hF;
        grant_log.delete();
        req_valid = 4'hF;
        wait_grants(4);
        req_valid = '0;
        wait_jobs(4);
        for (int i = 0; i < 4; i++) check("rr_order4", grant_log[i], exp4[i]);
        grant_log.delete();
        req_valid = 4'b1010;
        wait_grants(2);
        req_valid = '0;
        wait_jobs(6);
        for (int i = 0; i < 2; i++) check("rr_order2", grant_log[i], exp2[i]);
        rsp_ready = '0;
        tick;

        // Bypass with modulus 1 and modulus 0
        for (int pass = 0; pass < 2; pass++) begin
            set_req(2, 16'd10, (pass == 0) ? 16'd1 : 16'd0);
            req_valid = 4'b0100;
            tick;
            req_valid = '0;
            check("bypass_rsp_valid", {28'd0, rsp_valid}, 32'h4);
            check("bypass_rsp_data", {16'd0, rsp_data}, 32'd0);
            check("bypass_tp_i_valid", {31'd0, tp_i_valid}, 32'd0);
            rsp_ready = 4'b0100;
            tick;
            rsp_ready = '0;
        end

        // Backpressure on engine input, then on response
        tp_i_ready = 1'b0;
        set_req(0, 16'd5, 16'd13);
        set_req(1, 16'd4, 16'd9);
        req_valid = 4'b0001;
        tick;
        req_valid = 4'b0010;
        repeat (4) begin
            tick;
            check("bp_tp_power", {16'd0, tp_power}, 32'd5);
            check("bp_tp_modulus", {16'd0, tp_modulus}, 32'd13);
            check("bp_tp_i_valid", {31'd0, tp_i_valid}, 32'd1);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
        end
        tp_i_ready = 1'b1;
        wait_rsp(0);
        repeat (5) begin
            tick;
            check("bp_rsp_valid", {28'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", {16'd0, rsp_data}, 32'd6);
            check("bp_rsp_req_ready", {28'd0, req_ready}, 32'd0);
        end
        rsp_ready = 4'b0001;
        tick;
        rsp_ready = '0;
        tick;
        req_valid = '0;
        wait_rsp(1);
        check("bp_next_rsp_data", {16'd0, rsp_data}, 32'd7);
        rsp_ready = 4'b0010;
        tick;
        rsp_ready = '0;

        // Engine identity: 2^0 mod 7 = 1, wrong-index rsp_ready ignored
        set_req(0, 16'd0, 16'd7);
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        wait_rsp(0);
        check("ident_rsp_data", {16'd0, rsp_data}, 32'd1);
        jc = int'(job_count);
        rsp_ready = 4'b0010;
        repeat (3) begin
            tick;
            check("wrong_idx_rsp_valid", {28'd0, rsp_valid}, 32'd1);
            check("wrong_idx_job_count", {16'd0, job_count}, jc);
        end
        rsp_ready = 4'b0001;
        tick;
        rsp_ready = '0;
        check("ident_job_count", {16'd0, job_count}, jc + 1);

        // Reset while waiting on the engine
        set_req(1, 16'd3, 16'd11);
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        tick;
        check("pre_rst_tp_o_ready", {31'd0, tp_o_ready}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_tp_o_ready", {31'd0, tp_o_ready}, 32'd0);
        check("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("mid_rst_job_count", {16'd0, job_count}, 32'd0);
        set_req(0, 16'd2, 16'd5);
        set_req(1, 16'd7, 16'd100);
        req_valid = 4'b0011;
        repeat (3) tick;
        check("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
        grant_log.delete();
        rsp_ready = 4'hF;
        rst = 1'b1;
        wait_grants(2);
        req_valid = '0;
        wait_jobs(2);
        check("post_rst_first", grant_log[0], 0);
        check("post_rst_second", grant_log[1], 1);
        rsp_ready = '0;
        repeat (3) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
